// File: rtl/clk_phase_meter.sv
// rtl/clk_phase_meter.sv - measures ref_in/mon_in periods and ref-to-mon phase in iclk cycles.
// Define CLK_PHASE_METER_FREQ_DIFF_EN to produce freq_diff (mon_period - ref_period); otherwise freq_diff is 0.
module clk_phase_meter #(
  parameter int CNT_W = 16
) (
  input  logic             iclk,
  input  logic             rst,
  input  logic             ref_in,
  input  logic             mon_in,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] ref_period,
  output logic [CNT_W-1:0] mon_period,
  output logic [CNT_W-1:0] phase,
  output logic [CNT_W:0]   freq_diff,
  output logic             ovf
);

  typedef enum logic [1:0] {IDLE, ARM, MEAS, DONE} state_t;

  localparam logic [CNT_W-1:0] ALL1 = '1;
  localparam logic [CNT_W-1:0] ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       ref_sync_q, ref_sync_d, mon_sync_q, mon_sync_d;
  logic             ref_prev_q, ref_prev_d, mon_prev_q, mon_prev_d;
  logic             busy_q, busy_d, done_q, done_d, ovf_q, ovf_d;
  logic [CNT_W-1:0] ref_period_q, ref_period_d, mon_period_q, mon_period_d;
  logic [CNT_W-1:0] phase_q, phase_d, mon_start_q, mon_start_d;
  logic             ref_cap_q, ref_cap_d, mon_cap_q, mon_cap_d, mon_seen_q, mon_seen_d;
  logic             ref_rise, mon_rise;
`ifdef CLK_PHASE_METER_FREQ_DIFF_EN
  logic [CNT_W:0]   freq_diff_q, freq_diff_d;
`endif

  assign ref_rise = ref_sync_q[1] & ~ref_prev_q;
  assign mon_rise = mon_sync_q[1] & ~mon_prev_q;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    ref_sync_d   = {ref_sync_q[0], ref_in};
    mon_sync_d   = {mon_sync_q[0], mon_in};
    ref_prev_d   = ref_sync_q[1];
    mon_prev_d   = mon_sync_q[1];
    busy_d       = busy_q;
    done_d       = 1'b0;
    ovf_d        = ovf_q;
    ref_period_d = ref_period_q;
    mon_period_d = mon_period_q;
    phase_d      = phase_q;
    mon_start_d  = mon_start_q;
    ref_cap_d    = ref_cap_q;
    mon_cap_d    = mon_cap_q;
    mon_seen_d   = mon_seen_q;
`ifdef CLK_PHASE_METER_FREQ_DIFF_EN
    freq_diff_d  = freq_diff_q;
`endif

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d      = ARM;
          busy_d       = 1'b1;
          cnt_d        = '0;
          ovf_d        = 1'b0;
          ref_period_d = '0;
          mon_period_d = '0;
          phase_d      = '0;
          mon_start_d  = '0;
          ref_cap_d    = 1'b0;
          mon_cap_d    = 1'b0;
          mon_seen_d   = 1'b0;
        end
      end
      ARM: begin
        cnt_d = cnt_q + ONE;
        if (cnt_q == ALL1) begin
          state_d      = DONE;
          ovf_d        = 1'b1;
          ref_period_d = ALL1;
          mon_period_d = ALL1;
          phase_d      = ALL1;
        end else if (ref_rise) begin
          // The rise cycle itself counts as 0, so MEAS cycle k reads k.
          cnt_d   = ONE;
          state_d = MEAS;
          if (mon_rise) begin
            mon_seen_d  = 1'b1;
            phase_d     = '0;
            mon_start_d = '0;
          end
        end
      end
      MEAS: begin
        cnt_d = cnt_q + ONE;
        if (mon_rise) begin
          if (!mon_seen_q) begin
            mon_seen_d  = 1'b1;
            phase_d     = cnt_q;
            mon_start_d = cnt_q;
          end else if (!mon_cap_q) begin
            mon_cap_d    = 1'b1;
            mon_period_d = cnt_q - mon_start_q;
          end
        end
        if (ref_rise && !ref_cap_q) begin
          ref_cap_d    = 1'b1;
          ref_period_d = cnt_q;
        end
        if (ref_cap_d && mon_cap_d) begin
          state_d = DONE;
        end else if (cnt_q == ALL1) begin
          state_d = DONE;
          ovf_d   = 1'b1;
          if (!ref_cap_d)  ref_period_d = ALL1;
          if (!mon_cap_d)  mon_period_d = ALL1;
          if (!mon_seen_d) phase_d      = ALL1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (state_d == DONE && state_q != DONE) begin
      done_d = 1'b1;
      busy_d = 1'b0;
`ifdef CLK_PHASE_METER_FREQ_DIFF_EN
      freq_diff_d = {1'b0, mon_period_d} - {1'b0, ref_period_d};
`endif
    end
  end

  always_ff @(posedge iclk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      ref_sync_q   <= '0;
      mon_sync_q   <= '0;
      ref_prev_q   <= 1'b0;
      mon_prev_q   <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      ovf_q        <= 1'b0;
      ref_period_q <= '0;
      mon_period_q <= '0;
      phase_q      <= '0;
      mon_start_q  <= '0;
      ref_cap_q    <= 1'b0;
      mon_cap_q    <= 1'b0;
      mon_seen_q   <= 1'b0;
`ifdef CLK_PHASE_METER_FREQ_DIFF_EN
      freq_diff_q  <= '0;
`endif
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      ref_sync_q   <= ref_sync_d;
      mon_sync_q   <= mon_sync_d;
      ref_prev_q   <= ref_prev_d;
      mon_prev_q   <= mon_prev_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      ovf_q        <= ovf_d;
      ref_period_q <= ref_period_d;
      mon_period_q <= mon_period_d;
      phase_q      <= phase_d;
      mon_start_q  <= mon_start_d;
      ref_cap_q    <= ref_cap_d;
      mon_cap_q    <= mon_cap_d;
      mon_seen_q   <= mon_seen_d;
`ifdef CLK_PHASE_METER_FREQ_DIFF_EN
      freq_diff_q  <= freq_diff_d;
`endif
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign ovf        = ovf_q;
  assign ref_period = ref_period_q;
  assign mon_period = mon_period_q;
  assign phase      = phase_q;
`ifdef CLK_PHASE_METER_FREQ_DIFF_EN
  assign freq_diff  = freq_diff_q;
`else
  assign freq_diff  = '0;
`endif

endmodule

// File: doc/clk_phase_meter.md
CLK_PHASE_METER -- requirements
Module: clk_phase_meter

Interface
REQ-001 Parameter CNT_W, default 16: width of the period and phase counters and of their result fields.
REQ-002 iclk  input  1  sole clock; all state updates on its rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 ref_in  input  1  master (reference) clock under test, asynchronous to iclk.
REQ-005 mon_in  input  1  monitored (buffered/derived) clock under test, asynchronous to iclk.
REQ-006 start  input  1  one-cycle request to begin a measurement.
REQ-007 busy  output  1  high from the cycle after an accepted start until the cycle done is high.
REQ-008 done  output  1  one-cycle pulse marking a completed or aborted measurement.
REQ-009 ref_period  output  CNT_W  ref_in period in iclk cycles.
REQ-010 mon_period  output  CNT_W  mon_in period in iclk cycles.
REQ-011 phase  output  CNT_W  iclk cycles from the first ref_in rise to the first mon_in rise at or after it.
REQ-012 freq_diff  output  CNT_W+1  signed two's complement mon_period minus ref_period.
REQ-013 ovf  output  1  last measurement aborted on counter saturation.

Function
REQ-014 ref_in and mon_in shall each pass through a 2-flop synchronizer plus an edge register; a rise is the synchronized value high with the previous value low; both paths shall have identical latency.
REQ-015 FSM states: IDLE, ARM, MEAS, DONE.
REQ-016 IDLE: start high moves to ARM, clears the counter and ovf; start outside IDLE is ignored.
REQ-017 ARM: the counter increments each cycle; a ref rise loads the counter with 0 and moves to MEAS.
REQ-018 MEAS: the counter increments each cycle.
REQ-019 MEAS: the first mon rise, including one in the same cycle as the ref rise that entered MEAS (phase 0), captures the counter into phase and into a mon_start register.
REQ-020 MEAS: the second ref rise captures the counter into ref_period.
REQ-021 MEAS: the second mon rise captures counter minus mon_start into mon_period.
REQ-022 MEAS: simultaneous events in one cycle shall all be captured in that cycle.
REQ-023 MEAS moves to DONE in the cycle after both ref_period and mon_period are captured.
REQ-024 Counter at all-ones in ARM or MEAS: move to DONE, set ovf=1, set every uncaptured result field to all-ones.
REQ-025 DONE lasts one cycle: done=1, busy=0, freq_diff computed from the captured fields, then to IDLE.
REQ-026 Result fields and ovf shall hold their values until the next accepted start.

Reset
REQ-027 rst shall force IDLE at once in any state: busy=0, done=0, ovf=0, all result fields 0, counter 0, synchronizer and edge registers 0.
REQ-028 Reset asserted mid-measurement shall discard the measurement and produce no done pulse.

Configuration
REQ-029 Macro CLK_PHASE_METER_FREQ_DIFF_EN defined: freq_diff shall be computed as in REQ-025 with sign extension to CNT_W+1 bits.
REQ-030 Macro CLK_PHASE_METER_FREQ_DIFF_EN undefined: freq_diff shall be constant 0 with no subtractor present; all other behaviour is unchanged.

Verification
REQ-031 ref_in period 20 iclk cycles; mon_in identical but delayed 3 cycles; start -> ref_period=20, mon_period=20, phase=3, freq_diff=0, ovf=0, one done pulse.
REQ-032 ref_in period 20; mon_in period 24 rising together with ref_in -> phase=0, mon_period=24, freq_diff=+4 (macro defined) or 0 (macro undefined).
REQ-033 ref_in period 24; mon_in period 20 -> freq_diff=-4 (all-ones pattern ...11100 in CNT_W+1 bits).
REQ-034 CNT_W=8, ref_in held low after start -> done after 255 ARM cycles with ovf=1 and ref_period, mon_period, phase all 0xFF.
REQ-035 rst pulsed mid-MEAS -> busy=0 and all outputs 0 at once, no done; a subsequent start gives a correct REQ-031 result.
REQ-036 start pulsed again while busy -> ignored; results match a single measurement.
